// File: rtl/mgcmp_seq.sv
// mgcmp_seq: multi-cycle magnitude comparator.
//   Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first,
//   in unsigned or two's-complement mode, behind a start/busy/done handshake.
//
// Ports:
//   clk          system clock, rising-edge
//   rst          synchronous active-high reset (aborts a compare in progress)
//   start        request compare; only sampled while busy=0
//   signed_mode  1 = two's-complement, 0 = unsigned; latched with operands
//   a, b         operands, latched on an accepted start
//   busy         compare in progress
//   done         one-cycle pulse; x/y/z valid from this cycle
//   x, y, z      A > B, A == B, A < B (held until the next accepted start)
//
// Build option:
//   MGCMP_EARLY_EXIT_EN  defined: finish on the first differing chunk
//                        (latency 1..N). Undefined: always walk all N chunks
//                        (constant latency N); results are identical.
module mgcmp_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             x,
    output logic             y,
    output logic             z
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             sgn_q;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             chunk_gt;
    logic             chunk_lt;

`ifndef MGCMP_EARLY_EXIT_EN
    logic             decided;
    logic             decided_gt;
`endif

    assign busy = (state == S_RUN);

    // Latched operands shift left each step, so the chunk under test is
    // always the top CHUNK bits. Signed mode flips the sign bit of the
    // MSB chunk only, turning a two's-complement compare into unsigned.
    always_comb begin
        ca = a_sh[WIDTH-1 -: CHUNK];
        cb = b_sh[WIDTH-1 -: CHUNK];
        if (sgn_q && (idx == '0)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
        chunk_gt = (ca > cb);
        chunk_lt = (ca < cb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            sgn_q <= 1'b0;
            done  <= 1'b0;
            x     <= 1'b0;
            y     <= 1'b0;
            z     <= 1'b0;
`ifndef MGCMP_EARLY_EXIT_EN
            decided    <= 1'b0;
            decided_gt <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    sgn_q <= signed_mode;
                    idx   <= '0;
                    x     <= 1'b0;
                    y     <= 1'b0;
                    z     <= 1'b0;
                    state <= S_RUN;
`ifndef MGCMP_EARLY_EXIT_EN
                    decided    <= 1'b0;
                    decided_gt <= 1'b0;
`endif
                end
            end else begin
`ifdef MGCMP_EARLY_EXIT_EN
                if (chunk_gt || chunk_lt) begin
                    x     <= chunk_gt;
                    z     <= chunk_lt;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end else if (idx == LAST_IDX) begin
                    y     <= 1'b1;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end else begin
                    idx  <= idx + 1'b1;
                    a_sh <= a_sh << CHUNK;
                    b_sh <= b_sh << CHUNK;
                end
`else
                // The first differing chunk's verdict is sticky; on the last
                // chunk it wins over whatever that chunk says.
                if (idx == LAST_IDX) begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (decided) begin
                        x <= decided_gt;
                        z <= ~decided_gt;
                    end else begin
                        x <= chunk_gt;
                        z <= chunk_lt;
                        y <= ~(chunk_gt | chunk_lt);
                    end
                end else begin
                    if (!decided && (chunk_gt || chunk_lt)) begin
                        decided    <= 1'b1;
                        decided_gt <= chunk_gt;
                    end
                    idx  <= idx + 1'b1;
                    a_sh <= a_sh << CHUNK;
                    b_sh <= b_sh << CHUNK;
                end
`endif
            end
        end
    end

endmodule
